// File: rtl/tlb_unit.sv
//------------------------------------------------------------------------------
// tlb_unit: fully associative dual-page MIPS32 joint TLB with search/probe/read/write ports | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tlb_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [18:0]       s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [7:0]        s0_asid,
  output logic              s0_found,
  output logic [IDXW-1:0]   s0_index,
  output logic [19:0]       s0_pfn,
  output logic [2:0]        s0_c,
  output logic              s0_d,
  output logic              s0_v,

  input  logic [18:0]       s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [7:0]        s1_asid,
  output logic              s1_found,
  output logic [IDXW-1:0]   s1_index,
  output logic [19:0]       s1_pfn,
  output logic [2:0]        s1_c,
  output logic              s1_d,
  output logic              s1_v,

  input  logic              tlbp_req,
  input  logic [18:0]       tlbp_vpn2,
  input  logic [7:0]        tlbp_asid,
  output logic              tlbp_done,
  output logic              tlbp_found,
  output logic [IDXW-1:0]   tlbp_index,

  input  logic              we,
  input  logic [IDXW-1:0]   w_index,
  input  logic [18:0]       w_vpn2,
  input  logic [7:0]        w_asid,
  input  logic [19:0]       w_pfn0,
  input  logic [2:0]        w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic              w_g0,
  input  logic [19:0]       w_pfn1,
  input  logic [2:0]        w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  input  logic              w_g1,

  input  logic              tlbr_req,
  input  logic [IDXW-1:0]   r_index,
  output logic              r_done,
  output logic [18:0]       r_vpn2,
  output logic [7:0]        r_asid,
  output logic [19:0]       r_pfn0,
  output logic [2:0]        r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic              r_g0,
  output logic [19:0]       r_pfn1,
  output logic [2:0]        r_c1,
  output logic              r_d1,
  output logic              r_v1,
  output logic              r_g1
);

  // Entry storage
  logic [18:0] vpn2_q [TLBNUM];
  logic [7:0]  asid_q [TLBNUM];
  logic        glob_q [TLBNUM];
  logic [19:0] pfn0_q [TLBNUM];
  logic [2:0]  c0_q   [TLBNUM];
  logic        d0_q   [TLBNUM];
  logic        v0_q   [TLBNUM];
  logic [19:0] pfn1_q [TLBNUM];
  logic [2:0]  c1_q   [TLBNUM];
  logic        d1_q   [TLBNUM];
  logic        v1_q   [TLBNUM];

  // Registered probe/read results
  logic              tlbp_done_q;
  logic              tlbp_found_q;
  logic [IDXW-1:0]   tlbp_index_q;
  logic              r_done_q;
  logic [18:0]       r_vpn2_q;
  logic [7:0]        r_asid_q;
  logic              r_g_q;
  logic [19:0]       r_pfn0_q;
  logic [2:0]        r_c0_q;
  logic              r_d0_q;
  logic              r_v0_q;
  logic [19:0]       r_pfn1_q;
  logic [2:0]        r_c1_q;
  logic              r_d1_q;
  logic              r_v1_q;

  // Read-port next-state values (entry r_index as seen before the edge)
  logic [18:0]       r_vpn2_d;
  logic [7:0]        r_asid_d;
  logic              r_g_d;
  logic [19:0]       r_pfn0_d;
  logic [2:0]        r_c0_d;
  logic              r_d0_d;
  logic              r_v0_d;
  logic [19:0]       r_pfn1_d;
  logic [2:0]        r_c1_d;
  logic              r_d1_d;
  logic              r_v1_d;

  logic [IDXW:0]     s0_hit;
  logic [IDXW:0]     s1_hit;
  logic [IDXW:0]     p_hit;
  logic [24:0]       s0_page;
  logic [24:0]       s1_page;

  // Lowest-index match wins; returns {found, index}.
  function automatic logic [IDXW:0] hit(input logic [18:0] vpn2, input logic [7:0] asid);
    logic [IDXW:0] res;
    res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (vpn2_q[i] == vpn2 && (glob_q[i] || asid_q[i] == asid)) begin
        res = {1'b1, IDXW'(i)};
      end
    end
    return res;
  endfunction

  // Returns {pfn, c, d, v} of the selected page, zero on a miss.
  function automatic logic [24:0] page(input logic [IDXW:0] h, input logic odd);
    logic [24:0] res;
    res = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (h[IDXW] && h[IDXW-1:0] == IDXW'(i)) begin
        res = odd ? {pfn1_q[i], c1_q[i], d1_q[i], v1_q[i]}
                  : {pfn0_q[i], c0_q[i], d0_q[i], v0_q[i]};
      end
    end
    return res;
  endfunction

  always_comb begin
    s0_hit  = hit(s0_vpn2, s0_asid);
    s1_hit  = hit(s1_vpn2, s1_asid);
    p_hit   = hit(tlbp_vpn2, tlbp_asid);
    s0_page = page(s0_hit, s0_odd_page);
    s1_page = page(s1_hit, s1_odd_page);
  end

  assign s0_found = s0_hit[IDXW];
  assign s0_index = s0_hit[IDXW-1:0];
  assign {s0_pfn, s0_c, s0_d, s0_v} = s0_page;
  assign s1_found = s1_hit[IDXW];
  assign s1_index = s1_hit[IDXW-1:0];
  assign {s1_pfn, s1_c, s1_d, s1_v} = s1_page;

  // Indices without a backing entry read back as zero.
  always_comb begin
    r_vpn2_d = '0;
    r_asid_d = '0;
    r_g_d    = 1'b0;
    r_pfn0_d = '0;
    r_c0_d   = '0;
    r_d0_d   = 1'b0;
    r_v0_d   = 1'b0;
    r_pfn1_d = '0;
    r_c1_d   = '0;
    r_d1_d   = 1'b0;
    r_v1_d   = 1'b0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (r_index == IDXW'(i)) begin
        r_vpn2_d = vpn2_q[i];
        r_asid_d = asid_q[i];
        r_g_d    = glob_q[i];
        r_pfn0_d = pfn0_q[i];
        r_c0_d   = c0_q[i];
        r_d0_d   = d0_q[i];
        r_v0_d   = v0_q[i];
        r_pfn1_d = pfn1_q[i];
        r_c1_d   = c1_q[i];
        r_d1_d   = d1_q[i];
        r_v1_d   = v1_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        glob_q[i] <= 1'b0;
        pfn0_q[i] <= '0;
        c0_q[i]   <= '0;
        d0_q[i]   <= 1'b0;
        v0_q[i]   <= 1'b0;
        pfn1_q[i] <= '0;
        c1_q[i]   <= '0;
        d1_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && w_index == IDXW'(i)) begin
          vpn2_q[i] <= w_vpn2;
          asid_q[i] <= w_asid;
          glob_q[i] <= w_g0 & w_g1;
          pfn0_q[i] <= w_pfn0;
          c0_q[i]   <= w_c0;
          d0_q[i]   <= w_d0;
          v0_q[i]   <= w_v0;
          pfn1_q[i] <= w_pfn1;
          c1_q[i]   <= w_c1;
          d1_q[i]   <= w_d1;
          v1_q[i]   <= w_v1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tlbp_done_q  <= 1'b0;
      tlbp_found_q <= 1'b0;
      tlbp_index_q <= '0;
    end else begin
      tlbp_done_q <= tlbp_req;
      if (tlbp_req) begin
        tlbp_found_q <= p_hit[IDXW];
        tlbp_index_q <= p_hit[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_q <= 1'b0;
      r_vpn2_q <= '0;
      r_asid_q <= '0;
      r_g_q    <= 1'b0;
      r_pfn0_q <= '0;
      r_c0_q   <= '0;
      r_d0_q   <= 1'b0;
      r_v0_q   <= 1'b0;
      r_pfn1_q <= '0;
      r_c1_q   <= '0;
      r_d1_q   <= 1'b0;
      r_v1_q   <= 1'b0;
    end else begin
      r_done_q <= tlbr_req;
      if (tlbr_req) begin
        r_vpn2_q <= r_vpn2_d;
        r_asid_q <= r_asid_d;
        r_g_q    <= r_g_d;
        r_pfn0_q <= r_pfn0_d;
        r_c0_q   <= r_c0_d;
        r_d0_q   <= r_d0_d;
        r_v0_q   <= r_v0_d;
        r_pfn1_q <= r_pfn1_d;
        r_c1_q   <= r_c1_d;
        r_d1_q   <= r_d1_d;
        r_v1_q   <= r_v1_d;
      end
    end
  end

  assign tlbp_done  = tlbp_done_q;
  assign tlbp_found = tlbp_found_q;
  assign tlbp_index = tlbp_index_q;

  assign r_done = r_done_q;
  assign r_vpn2 = r_vpn2_q;
  assign r_asid = r_asid_q;
  assign r_pfn0 = r_pfn0_q;
  assign r_c0   = r_c0_q;
  assign r_d0   = r_d0_q;
  assign r_v0   = r_v0_q;
  assign r_g0   = r_g_q;
  assign r_pfn1 = r_pfn1_q;
  assign r_c1   = r_c1_q;
  assign r_d1   = r_d1_q;
  assign r_v1   = r_v1_q;
  assign r_g1   = r_g_q;

endmodule

`default_nettype wire

// File: tb/tb_tlb_unit.sv
//------------------------------------------------------------------------------
// tb_tlb_unit: scoreboard bench for tlb_unit against an entry-table model | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2, tlbp_vpn2, w_vpn2, r_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid, tlbp_asid, w_asid, r_asid;
  logic        s0_found, s1_found, s0_d, s0_v, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index, tlbp_index, w_index, r_index;
  logic [19:0] s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
  logic        tlbp_req, tlbp_done, tlbp_found;
  logic        we, w_d0, w_v0, w_g0, w_d1, w_v1, w_g1;
  logic        tlbr_req, r_done, r_d0, r_v0, r_g0, r_d1, r_v1, r_g1;

  always #5 clk = ~clk;

  tlb_unit #(.TLBNUM(16), .IDXW(4)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .tlbp_req(tlbp_req), .tlbp_vpn2(tlbp_vpn2), .tlbp_asid(tlbp_asid),
    .tlbp_done(tlbp_done), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0), .w_g0(w_g0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1), .w_g1(w_g1),
    .tlbr_req(tlbr_req), .r_index(r_index), .r_done(r_done), .r_vpn2(r_vpn2), .r_asid(r_asid),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0), .r_g0(r_g0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .r_g1(r_g1)
  );

  // Reference TLB contents: a plain table of entries, page selected by [entry][page].
  logic [18:0] m_vpn2 [16];
  logic [7:0]  m_asid [16];
  logic        m_g    [16];
  logic [19:0] m_pfn  [16][2];
  logic [2:0]  m_c    [16][2];
  logic        m_d    [16][2];
  logic        m_v    [16][2];

  typedef struct {
    logic [78:0] data;
    int          due;
  } exp_t;

  exp_t        pq[$];
  exp_t        rq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [4:0]  last_p = '0;
  logic [78:0] last_r = '0;
  logic [18:0] pool [4] = '{19'h12345, 19'h00400, 19'h0ABCD, 19'h00001};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [29:0] ref_search(input logic [18:0] vpn2, input logic [7:0] asid,
                                             input logic odd);
    for (int i = 0; i < 16; i++) begin
      if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) begin
        return {1'b1, i[3:0], m_pfn[i][odd], m_c[i][odd], m_d[i][odd], m_v[i][odd]};
      end
    end
    return '0;
  endfunction

  function automatic logic [78:0] ref_read(input logic [3:0] idx);
    return {m_vpn2[idx], m_asid[idx],
            m_pfn[idx][0], m_c[idx][0], m_d[idx][0], m_v[idx][0], m_g[idx],
            m_pfn[idx][1], m_c[idx][1], m_d[idx][1], m_v[idx][1], m_g[idx]};
  endfunction

  function automatic logic [78:0] dut_read();
    return {r_vpn2, r_asid, r_pfn0, r_c0, r_d0, r_v0, r_g0, r_pfn1, r_c1, r_d1, r_v1, r_g1};
  endfunction

  function automatic logic [18:0] pick();
    int k;
    k = $urandom_range(0, 4);
    if (k < 4) return pool[k];
    return 19'($urandom);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_pfn[i][p] = '0; m_c[i][p] = '0; m_d[i][p] = 1'b0; m_v[i][p] = 1'b0;
      end
    end
  endtask

  // Called at posedge+1: checks searches, queues probe/read expectations, crosses one edge.
  task automatic tick();
    logic [29:0] ps;
    exp_t        e;
    #3;
    chk("s0_search", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, ref_search(s0_vpn2, s0_asid, s0_odd_page));
    chk("s1_search", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, ref_search(s1_vpn2, s1_asid, s1_odd_page));
    if (tlbp_req) begin
      ps = ref_search(tlbp_vpn2, tlbp_asid, 1'b0);
      e.data = {74'b0, ps[29:25]};
      e.due  = cyc + 1;
      pq.push_back(e);
    end
    if (tlbr_req) begin
      e.data = ref_read(r_index);
      e.due  = cyc + 1;
      rq.push_back(e);
    end
    @(posedge clk);
    if (we) begin
      m_vpn2[w_index] = w_vpn2;
      m_asid[w_index] = w_asid;
      m_g[w_index]    = w_g0 & w_g1;
      m_pfn[w_index][0] = w_pfn0; m_c[w_index][0] = w_c0; m_d[w_index][0] = w_d0; m_v[w_index][0] = w_v0;
      m_pfn[w_index][1] = w_pfn1; m_c[w_index][1] = w_c1; m_d[w_index][1] = w_d1; m_v[w_index][1] = w_v1;
    end
    #1;
    we = 1'b0; tlbp_req = 1'b0; tlbr_req = 1'b0;
  endtask

  task automatic set_w(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                       input logic [19:0] pfn0, input logic [19:0] pfn1, input logic g0, input logic g1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid;
    w_pfn0 = pfn0; w_c0 = 3'd3; w_d0 = 1'b1; w_v0 = 1'b1; w_g0 = g0;
    w_pfn1 = pfn1; w_c1 = 3'd2; w_d1 = 1'b0; w_v1 = 1'b1; w_g1 = g1;
  endtask

  task automatic set_s(input logic port, input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
    if (port) begin s1_vpn2 = vpn2; s1_asid = asid; s1_odd_page = odd; end
    else      begin s0_vpn2 = vpn2; s0_asid = asid; s0_odd_page = odd; end
  endtask

  // Monitor: pops scoreboard entries whenever a done pulse appears, else checks hold.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (tlbp_done) begin
        if (pq.size() == 0) chk("tlbp_done_unexpected", 80'(tlbp_done), 80'(0));
        else begin
          e = pq.pop_front();
          chk("tlbp_latency", 80'(cyc), 80'(e.due));
          chk("tlbp_result", {75'b0, tlbp_found, tlbp_index}, 80'(e.data));
          last_p = e.data[4:0];
        end
      end else begin
        chk("tlbp_hold", {75'b0, tlbp_found, tlbp_index}, {75'b0, last_p});
      end
      if (r_done) begin
        if (rq.size() == 0) chk("r_done_unexpected", 80'(r_done), 80'(0));
        else begin
          e = rq.pop_front();
          chk("tlbr_latency", 80'(cyc), 80'(e.due));
          chk("tlbr_result", {1'b0, dut_read()}, {1'b0, e.data});
          last_r = e.data;
        end
      end else begin
        chk("tlbr_hold", {1'b0, dut_read()}, {1'b0, last_r});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {s0_vpn2, s0_asid, s0_odd_page, s1_vpn2, s1_asid, s1_odd_page} = '0;
    {tlbp_req, tlbp_vpn2, tlbp_asid, tlbr_req, r_index} = '0;
    {we, w_index, w_vpn2, w_asid, w_pfn0, w_c0, w_d0, w_v0, w_g0, w_pfn1, w_c1, w_d1, w_v1, w_g1} = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tlbp_done", 80'(tlbp_done), 80'(0));
    chk("reset_r_done", 80'(r_done), 80'(0));
    chk("reset_tlbp_out", {75'b0, tlbp_found, tlbp_index}, 80'(0));
    chk("reset_r_out", {1'b0, dut_read()}, 80'(0));
    reset = 1'b0;

    // Empty TLB misses
    set_s(1'b0, 19'h00001, 8'h05, 1'b0);
    #3;
    chk("empty_s0", {s0_found, s0_index, s0_pfn}, 80'(0));
    tick();

    // Non-global entry at index 3
    set_w(4'd3, 19'h12345, 8'h07, 20'hAAAAA, 20'hBBBBB, 1'b0, 1'b0);
    tick();
    set_s(1'b1, 19'h12345, 8'h07, 1'b1);
    #3;
    chk("idx3_hit", {s1_found, s1_index, s1_pfn}, {55'b0, 1'b1, 4'd3, 20'hBBBBB});
    tick();
    set_s(1'b1, 19'h12345, 8'h08, 1'b1);
    #3;
    chk("idx3_asid_miss", 80'(s1_found), 80'(0));
    tick();

    // G requires both page global bits
    set_w(4'd5, 19'h00400, 8'h10, 20'h00055, 20'h00066, 1'b1, 1'b0);
    tick();
    set_s(1'b0, 19'h00400, 8'h33, 1'b0);
    #3;
    chk("half_global_miss", 80'(s0_found), 80'(0));
    tick();
    set_w(4'd5, 19'h00400, 8'h10, 20'h00055, 20'h00066, 1'b1, 1'b1);
    tick();
    set_s(1'b0, 19'h00400, 8'hFF, 1'b0);
    tlbr_req = 1'b1; r_index = 4'd5;
    #3;
    chk("global_hit", {s0_found, s0_index}, {75'b0, 1'b1, 4'd5});
    tick();
    chk("global_read", {r_done, r_g0, r_g1}, 80'b111);

    // Duplicate entries resolve to the lowest index
    set_w(4'd2, 19'h0ABCD, 8'h22, 20'h22222, 20'h23232, 1'b0, 1'b0);
    tick();
    set_w(4'd9, 19'h0ABCD, 8'h22, 20'h99999, 20'h98989, 1'b0, 1'b0);
    tick();
    set_s(1'b0, 19'h0ABCD, 8'h22, 1'b0);
    tlbp_req = 1'b1; tlbp_vpn2 = 19'h0ABCD; tlbp_asid = 8'h22;
    #3;
    chk("dup_s0_index", {s0_found, s0_index}, {75'b0, 1'b1, 4'd2});
    tick();
    chk("dup_probe", {tlbp_done, tlbp_found, tlbp_index}, {74'b0, 2'b11, 4'd2});
    tlbp_req = 1'b1; tlbp_vpn2 = 19'h7FFFF;
    tick();
    chk("probe_miss", {tlbp_done, tlbp_found, tlbp_index}, {74'b0, 2'b10, 4'd0});

    // Write, read and probe of index 3 in the same cycle
    set_w(4'd3, 19'h12345, 8'h07, 20'h11111, 20'hBBBBB, 1'b0, 1'b0);
    tlbr_req = 1'b1; r_index = 4'd3;
    tlbp_req = 1'b1; tlbp_vpn2 = 19'h12345; tlbp_asid = 8'h07;
    tick();
    chk("same_cycle_read_old", 80'(r_pfn0), 80'(20'hAAAAA));
    chk("same_cycle_probe", {tlbp_found, tlbp_index}, {75'b0, 1'b1, 4'd3});
    tlbr_req = 1'b1; r_index = 4'd3;
    tick();
    chk("read_new", 80'(r_pfn0), 80'(20'h11111));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 2) == 0);
      w_index = 4'($urandom); w_vpn2 = pick(); w_asid = 8'($urandom_range(0, 3));
      w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
      w_g0 = 1'($urandom);
      w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
      w_g1 = 1'($urandom);
      tlbp_req = ($urandom_range(0, 2) == 0); tlbp_vpn2 = pick(); tlbp_asid = 8'($urandom_range(0, 3));
      tlbr_req = ($urandom_range(0, 2) == 0); r_index = 4'($urandom);
      set_s(1'b0, pick(), 8'($urandom_range(0, 3)), 1'($urandom));
      set_s(1'b1, pick(), 8'($urandom_range(0, 3)), 1'($urandom));
      tick();
    end

    // Reset while a probe is pending suppresses the done pulse
    set_w(4'd3, 19'h12345, 8'h07, 20'hAAAAA, 20'hBBBBB, 1'b0, 1'b0);
    tick();
    repeat (2) tick();
    tlbp_req = 1'b1; tlbp_vpn2 = 19'h12345; tlbp_asid = 8'h07;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_suppress_done", 80'(tlbp_done), 80'(0));
    chk("reset_clear_probe", {tlbp_found, tlbp_index}, 80'(0));
    tlbp_req = 1'b0;
    clear_model();
    last_p = '0;
    last_r = '0;
    reset = 1'b0;
    set_s(1'b0, 19'h12345, 8'h07, 1'b0);
    #3;
    chk("after_reset_miss", 80'(s0_found), 80'(0));
    tick();
    repeat (2) tick();

    chk("probe_queue_drained", 80'(pq.size()), 80'(0));
    chk("read_queue_drained", 80'(rq.size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- 16-entry, fully associative, dual-page (even/odd) MIPS32 joint TLB. It is the TLB-side endpoint of the CP0 EntryHi/EntryLo0/EntryLo1/Index interface.
- Serves three kinds of request:
  - two combinational translation search ports: s0 for fetch, s1 for load/store;
  - a registered probe channel for tlbp and a registered read channel for tlbr, both returning results to CP0;
  - a write port for tlbwi/tlbwr, fed from the CP0 register outputs.

Parameters:
TLBNUM, 16, number of entries.
IDXW, 4, index width, equal to log2(TLBNUM).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
s0_vpn2  in  19  fetch VA[31:13]
s0_odd_page  in  1  fetch VA[12]
s0_asid  in  8  current ASID
s0_found  out  1  fetch hit
s0_index  out  4  hit entry index
s0_pfn  out  20  selected page PFN
s0_c  out  3  selected page cache attribute
s0_d  out  1  selected page dirty bit
s0_v  out  1  selected page valid bit
s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v  same as s0, for data accesses
tlbp_req  in  1  probe request, one-cycle pulse
tlbp_vpn2  in  19  CP0 EntryHi VPN2
tlbp_asid  in  8  CP0 EntryHi ASID
tlbp_done  out  1  probe result valid, one-cycle pulse
tlbp_found  out  1  probe hit
tlbp_index  out  4  probe hit index
we  in  1  write enable
w_index  in  4  write entry index
w_vpn2  in  19  write VPN2
w_asid  in  8  write ASID
w_pfn0  in  20  even page PFN
w_c0  in  3  even page cache attribute
w_d0  in  1  even page dirty bit
w_v0  in  1  even page valid bit
w_g0  in  1  even page global bit
w_pfn1, w_c1, w_d1, w_v1, w_g1  in  20/3/1/1/1  odd page fields
tlbr_req  in  1  read request, one-cycle pulse
r_index  in  4  read entry index
r_done  out  1  read data valid, one-cycle pulse
r_vpn2  out  19  read-back VPN2
r_asid  out  8  read-back ASID
r_pfn0, r_c0, r_d0, r_v0, r_g0  out  20/3/1/1/1  even page read-back
r_pfn1, r_c1, r_d1, r_v1, r_g1  out  20/3/1/1/1  odd page read-back

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset clears every entry field (including V0/V1 and G) and every registered output: tlbp_done, tlbp_found, tlbp_index, r_done and all r_* go to 0.
- Entry storage:
  - Each entry holds VPN2, ASID, a single G bit, and PFN/C/D/V for each of page 0 and page 1.
  - Stored G = w_g0 & w_g1.
  - On a read, both r_g0 and r_g1 return the stored G.
- Write:
  - When we=1, entry w_index is written at the clk rising edge.
  - A write with no other request active takes 1 cycle and has no output pulse.
- Match rule: entry i matches when VPN2[i]==vpn2 and (G[i] or ASID[i]==asid). The V bit does not gate a match.
- Search ports s0/s1:
  - Purely combinational, zero latency.
  - found = OR of all matches.
  - index = lowest matching index; multiple hits are a software error and resolve by priority.
  - odd_page=1 selects the page-1 fields, otherwise the page-0 fields.
  - On a miss, index/pfn/c/d/v are 0.
  - Search always sees the entry contents before the clock edge: a same-cycle write does not affect that cycle's result.
- Probe channel (registered):
  - A tlbp_req sampled in cycle N produces tlbp_done=1 in cycle N+1 only, with tlbp_found and tlbp_index.
  - On a miss, tlbp_index=0.
  - tlbp_found and tlbp_index hold their values until the next probe.
  - The probe uses pre-edge contents. A we to the matching entry in cycle N does not change the N+1 result.
  - Back-to-back requests give back-to-back done pulses.
- Read channel (registered):
  - A tlbr_req in cycle N produces r_done=1 in cycle N+1, and r_* shows entry r_index as it was in cycle N (old data if we hits the same index in cycle N).
  - r_* holds until the next read.
- Simultaneous tlbp_req, tlbr_req and we: all three are accepted and independent; no stalls, no ready signals.
- Reset asserted while a probe or read is pending: the done pulse is suppressed and the outputs clear asynchronously.
- Out-of-range indices are impossible with TLBNUM=16. If TLBNUM<16, a write to an index ≥TLBNUM is ignored and a read of such an index returns 0.

Test Plan:
- Reset, then s0 search vpn2=0x00001, asid=0x05 -> s0_found=0, s0_pfn=0, s0_index=0; r_done=0, tlbp_done=0.
- Write idx 3: vpn2=0x12345, asid=0x07, g0=g1=0, pfn0=0xAAAAA, pfn1=0xBBBBB, v0=v1=1. Next cycle, s1 vpn2=0x12345, asid=0x07, odd=1 -> s1_found=1, index=3, pfn=0xBBBBB. Same request with asid=0x08 -> found=0.
- Write idx 5 with g0=1, g1=0, vpn2=0x00400 -> search with any asid misses. Rewrite with g0=g1=1 -> search with asid=0xFF hits index 5; tlbr idx 5 -> r_done=1 next cycle, r_g0=r_g1=1.
- Entries 2 and 9 hold identical vpn2/asid -> s0_index=2. tlbp_req for that pair -> tlbp_done=1 one cycle later, found=1, index=2; tlbp on an absent vpn2 -> found=0, index=0.
- Same cycle: we to idx 3 (new pfn0=0x11111), tlbr_req idx 3, and tlbp_req matching idx 3 -> next cycle r_pfn0=0xAAAAA (old) and tlbp_found=1, index=3. A second tlbr one cycle later -> r_pfn0=0x11111.
- Assert reset in the cycle after a tlbp_req, before the edge -> tlbp_done stays 0. All entries invalid afterwards: a search for 0x12345 misses.
